// File: rtl/socbus_fifo_pkg.sv
// Shared FIFO helpers: level width rule, clog2, threshold legality.
// Used by fifo_sync_th and the bridge FIFOs.
package socbus_fifo_pkg;

  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic bit thresh_ok(
    input int aw,
    input int af,
    input int ae
  );
    int d;
    d = 1 << aw;
    return (af >= 1) && (af <= d) &&
           (ae >= 0) && (ae <= d - 1);
  endfunction

endpackage

// File: rtl/fifo_sync_th_mem.sv
// DEPTH x DWIDTH storage: one sync write port, one async read port.
// Shared with the bridge FIFOs.
module fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // write port; storage is never cleared
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_th.sv
// Show-ahead sync FIFO with level, almost flags, flush, sticky errors.
// Define FIFO_SYNC_TH_ERR_EN to build the overflow/underflow registers.
module fifo_sync_th
  import socbus_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr,
  input  logic [DWIDTH-1:0]   w_data,
  input  logic                rd,
  output logic [DWIDTH-1:0]   r_data,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [AWIDTH:0]     level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int LW    = lvl_w(AWIDTH);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  if (!thresh_ok(AWIDTH, AF_THRESH, AE_THRESH)) begin : g_bad
    $error("fifo_sync_th: AF_THRESH/AE_THRESH out of range");
  end

  logic [AWIDTH-1:0] wp_q, rp_q;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              empty_q, full_q, ae_q, af_q;
  logic              rd_acc, wr_acc, we;

  assign rd_acc = rd & ~empty_q;
  assign wr_acc = wr & (~full_q | rd);
  assign we     = wr_acc & ~flush & ~rst;
  assign lvl_d  = lvl_q + LW'(wr_acc) - LW'(rd_acc);

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wp_q),
    .wdata_i (w_data),
    .raddr_i (rp_q),
    .rdata_o (r_data)
  );

  // pointers, level and flags; flags follow lvl_d so they match level
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      if (wr_acc) wp_q <= wp_q + 1'b1;
      if (rd_acc) rp_q <= rp_q + 1'b1;
      lvl_q   <= lvl_d;
      empty_q <= (lvl_d == '0);
      full_q  <= (lvl_d == DEPTH_L);
      ae_q    <= (lvl_d <= AE_L);
      af_q    <= (lvl_d >= AF_L);
    end
  end

`ifdef FIFO_SYNC_TH_ERR_EN
  logic ovf_q, unf_q;

  // sticky error flags, cleared only by rst or flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr & ~wr_acc);
      unf_q <= unf_q | (rd & empty_q);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = lvl_q;

endmodule

// File: tb/tb_fifo_sync_th.sv
// Directed bench for fifo_sync_th at DEPTH=16, AF=12, AE=3.
// Error flag expectations follow FIFO_SYNC_TH_ERR_EN.
module tb_fifo_sync_th;

`ifdef FIFO_SYNC_TH_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, wr, rd;
  logic [7:0] w_data, r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] level;
  logic       overflow, underflow;

  int checks = 0;
  int failures = 0;

  fifo_sync_th dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wr_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; w_data = 8'(base + i);
      step();
    end
    wr = 1'b0;
  endtask

  task automatic rd_n(input int n);
    rd = 1'b1;
    repeat (n) step();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b req 0 1 0 1 0 0 0",
               level, empty, full, almost_empty, almost_full, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      step();
      checks++;
      if (level !== 5'(i + 1) || almost_empty !== (i + 1 <= 3) ||
          almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16) ||
          empty !== 1'b0) begin
        failures++;
        $display("FAIL fill[%0d]: lvl=%0d ae=%b af=%b f=%b e=%b req lvl=%0d",
                 i, level, almost_empty, almost_full, full, empty, i + 1);
      end
    end
    w_data = 8'hEE;
    step();
    wr = 1'b0;
    checks++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== ERR) begin
      failures++;
      $display("FAIL overflow: lvl=%0d f=%b ov=%b req 16 1 %b",
               level, full, overflow, ERR);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (r_data !== 8'(i) || empty !== 1'b0) begin
        failures++;
        $display("FAIL drain[%0d]: r_data=%h e=%b req %h 0", i, r_data, empty, 8'(i));
      end
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1 || level !== 5'd0 || almost_empty !== 1'b1) begin
      failures++;
      $display("FAIL drained: e=%b lvl=%0d ae=%b req 1 0 1", empty, level, almost_empty);
    end
    rd_n(1);
    checks++;
    if (underflow !== ERR || level !== 5'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL underflow: un=%b lvl=%0d e=%b req %b 0 1", underflow, level, empty, ERR);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    wr_n(16, 0);
    rd = 1'b1; wr = 1'b1; w_data = 8'hAA;
    step();
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || r_data !== 8'h01) begin
      failures++;
      $display("FAIL full_rw: lvl=%0d f=%b ov=%b r=%h req 16 1 0 01",
               level, full, overflow, r_data);
    end
    rd_n(15);
    checks++;
    if (r_data !== 8'hAA || level !== 5'd1) begin
      failures++;
      $display("FAIL full_rw_tail: r=%h lvl=%0d req aa 1", r_data, level);
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    rd = 1'b1; wr = 1'b1; w_data = 8'h55;
    step();
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (level !== 5'd1 || r_data !== 8'h55 || empty !== 1'b0 || underflow !== ERR) begin
      failures++;
      $display("FAIL empty_rw: lvl=%0d r=%h e=%b un=%b req 1 55 0 %b",
               level, r_data, empty, underflow, ERR);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    wr_n(10, 8'h90);
    rd_n(10);
    wr_n(10, 8'h20);
    checks++;
    if (level !== 5'd10) begin
      failures++;
      $display("FAIL wrap_lvl: lvl=%0d req 10", level);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (r_data !== 8'(8'h20 + i)) begin
        failures++;
        $display("FAIL wrap[%0d]: r=%h req %h", i, r_data, 8'(8'h20 + i));
      end
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    rd_n(1);
    wr_n(17, 0);
    rd_n(9);
    checks++;
    if (level !== 5'd7 || overflow !== ERR || underflow !== ERR) begin
      failures++;
      $display("FAIL pre_flush: lvl=%0d ov=%b un=%b req 7 %b %b",
               level, overflow, underflow, ERR, ERR);
    end
    flush = 1'b1; wr = 1'b1; w_data = 8'h77;
    step();
    flush = 1'b0; wr = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL flush: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b req 0 1 0 1 0 0 0",
               level, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    wr_n(1, 8'h12);
    checks++;
    if (level !== 5'd1 || r_data !== 8'h12) begin
      failures++;
      $display("FAIL post_flush: lvl=%0d r=%h req 1 12", level, r_data);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    rd_n(1);
    wr_n(5, 8'h40);
    rst = 1'b1; wr = 1'b1; w_data = 8'h66;
    step();
    rst = 1'b0; wr = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b req 0 1 0 1 0 0 0",
               level, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    wr_n(1, 8'h3C);
    checks++;
    if (r_data !== 8'h3C || level !== 5'd1) begin
      failures++;
      $display("FAIL post_reset: r=%h lvl=%0d req 3c 1", r_data, level);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_th.md
Name: fifo_sync_th

Overview:
- Single-clock show-ahead FIFO with a full-depth level counter, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Successor to the basic bus FIFO: all 2**AWIDTH entries are usable, and the level counter is wide enough to report a completely full FIFO.
- Used as the buffering stage in bus bridges and peripheral RX/TX paths.

Parameters:
- DWIDTH, 8, data width in bits.
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries.
- AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 3, almost_empty asserts when level <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of FIFO contents and error flags.
- wr  in  1  write request.
- w_data  in  DWIDTH  write data.
- rd  in  1  read request; pops the entry currently on r_data.
- r_data  out  DWIDTH  head entry, combinational from storage; valid only while empty=0.
- empty  out  1  registered; level==0.
- full  out  1  registered; level==DEPTH.
- almost_empty  out  1  registered; level<=AE_THRESH.
- almost_full  out  1  registered; level>=AF_THRESH.
- level  out  AWIDTH+1  registered occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was dropped.
- underflow  out  1  sticky; a read of an empty FIFO occurred.

Behaviour:
- Reset: one clock with rst=1 gives pointers=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage is not cleared. rst has priority over flush, rd and wr. Reset mid-operation discards all contents.
- Accept rules, from registered state:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd).
  - A full FIFO with rd=wr=1 reads and writes in the same cycle; level is unchanged.
  - An empty FIFO with rd=wr=1 performs the write only; the read is ignored and underflow is set.
- Pointers: AWIDTH bits. Each advances by 1 on its accept and wraps naturally from DEPTH-1 to 0.
- Storage: written at w_ptr on wr_acc at the clock edge. A write into the slot being read in the same cycle does not disturb that cycle's r_data.
- Level: level_next = level + wr_acc - rd_acc, computed at AWIDTH+1 bits; it never over- or under-flows.
- Flags: empty, full, almost_* are computed from level_next and registered, so they are always consistent with level in the same cycle.
- Latency: a write at edge N is visible on r_data, with empty=0, after edge N. The first-write-to-read latency is 1 cycle.
- Flush: on a cycle with flush=1 (and rst=0):
  - pointers and level go to 0; flags take their reset values; overflow and underflow are cleared.
  - rd and wr are ignored that cycle.
- Errors, set on the following edge and held until rst or flush:
  - overflow: wr & ~wr_acc.
  - underflow: rd & empty.
- No state machine beyond the pointer/level registers; the FIFO state is fully determined by level.

Optional Feature:
- FIFO_SYNC_TH_ERR_EN defined: overflow and underflow behave as above.
- Not defined: no error registers are built; overflow and underflow are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package socbus_fifo_pkg holds:
  - the level-width constant rule (AWIDTH+1);
  - a clog2 function for callers sizing AWIDTH from a depth;
  - the parameter legality checks (AF_THRESH, AE_THRESH range).
- One sub-module, fifo_mem: DEPTH x DWIDTH array with one synchronous write port and one asynchronous read port. It is reused by the bridge FIFOs.
- The control logic (pointers, level, flags, errors) stays in fifo_sync_th.

Test Plan (defaults: DEPTH=16, AF=12, AE=3):
- Reset, then 16 writes of 0x00..0x0F without reads:
  - level steps 1..16;
  - almost_empty deasserts when level reaches 4;
  - almost_full asserts when level reaches 12;
  - full=1 at level 16;
  - a 17th write is dropped and overflow=1.
- From full, 16 reads: r_data sequence is 0x00..0x0F, then empty=1 and level=0. A further read sets underflow=1, with level still 0.
- Full FIFO, rd=wr=1 with w_data=0xAA: r_data pops 0x00, level stays 16, full stays 1, overflow stays 0. After 15 further reads, 0xAA appears at the head.
- Empty FIFO, rd=wr=1 with w_data=0x55: level=1, r_data=0x55 on the next cycle, underflow=1.
- Wrap: 10 writes, 10 reads, then 10 writes of 0x20..0x29 (pointers wrap past 15). Reads return 0x20..0x29 in order.
- Level 7 with errors set, then flush=1 together with wr=1: next cycle level=0, empty=1, overflow=0, underflow=0, and the write is ignored. Repeat with rst=1 mid-burst: the same reset values result.
